// File: rtl/sm_regdump.sv
// Register-dump sequencer: sweeps sm_top debug-port addresses FIRST_REG..LAST_REG and
// streams each word over a valid/ready port. Define SM_REGDUMP_CHECKSUM_EN to append an XOR checksum word.
module sm_regdump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [31:0] outData,
  output logic [5:0]  outIndex,
  output logic        outValid,
  input  logic        outReady,
  output logic        outLast,
  output logic        busy
);

  localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
  localparam logic [4:0] LAST_A  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SEND
`ifdef SM_REGDUMP_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  state_t state, state_next;

`ifdef SM_REGDUMP_CHECKSUM_EN
  logic [31:0] acc;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = SETUP;
      SETUP: state_next = SEND;
      SEND: begin
        if (outReady) begin
          if (outLast) state_next = IDLE;
`ifdef SM_REGDUMP_CHECKSUM_EN
          else if (regAddr == LAST_A) state_next = CHECK;
`endif
          else state_next = SETUP;
        end
      end
`ifdef SM_REGDUMP_CHECKSUM_EN
      CHECK: state_next = SEND;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Datapath: outputs are registered; outLast doubles as the "final word" marker in SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regAddr  <= '0;
      outData  <= '0;
      outIndex <= '0;
      outValid <= 1'b0;
      outLast  <= 1'b0;
      busy     <= 1'b0;
`ifdef SM_REGDUMP_CHECKSUM_EN
      acc      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            regAddr  <= FIRST_A;
            outIndex <= '0;
            busy     <= 1'b1;
`ifdef SM_REGDUMP_CHECKSUM_EN
            acc      <= '0;
`endif
          end
        end
        SETUP: begin
          outData  <= regData;
          outValid <= 1'b1;
`ifdef SM_REGDUMP_CHECKSUM_EN
          outLast  <= 1'b0;
          acc      <= acc ^ regData;
`else
          outLast  <= (regAddr == LAST_A);
`endif
        end
        SEND: begin
          if (outReady) begin
            outValid <= 1'b0;
            outLast  <= 1'b0;
            if (outLast) begin
              busy <= 1'b0;
            end else begin
              outIndex <= outIndex + 6'd1;
              // Stay parked on LAST_REG while the checksum word goes out.
              if (regAddr != LAST_A) regAddr <= regAddr + 5'd1;
            end
          end
        end
`ifdef SM_REGDUMP_CHECKSUM_EN
        CHECK: begin
          outData  <= acc;
          outValid <= 1'b1;
          outLast  <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
